// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one memory port between the fetch and data requesters
// Data requests win ties unless fetch has lost STARVE_LIMIT grants in a row.
module unified_mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_rmask,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   output logic        arb_err
);

   typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IRESP, DRESP} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state;
   logic [3:0] starve_cnt;
   logic       i_pend;
   logic       d_pend;
   logic       d_store;
   logic       d_win;

   assign i_pend  = |imem_rmask;
   assign d_store = |dmem_wmask;
   assign d_pend  = (|dmem_rmask) | d_store;
   assign d_win   = d_pend && !(i_pend && starve_cnt == LIMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         mem_addr   <= 32'd0;
         mem_rmask  <= 4'd0;
         mem_wmask  <= 4'd0;
         mem_wdata  <= 32'd0;
         imem_rdata <= 32'd0;
         dmem_rdata <= 32'd0;
         imem_resp  <= 1'b0;
         dmem_resp  <= 1'b0;
         arb_err    <= 1'b0;
      end else begin
         imem_resp <= 1'b0;
         dmem_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (d_win) begin
                  state     <= DBUSY;
                  mem_addr  <= dmem_addr;
                  mem_wdata <= dmem_wdata;
                  mem_wmask <= dmem_wmask;
                  // A request carrying both masks is performed as a store
                  mem_rmask <= d_store ? 4'd0 : dmem_rmask;
                  if ((|dmem_rmask) && d_store) begin
                     arb_err <= 1'b1;
                  end
                  if (i_pend) begin
                     starve_cnt <= (starve_cnt < LIMIT) ? starve_cnt + 4'd1 : LIMIT;
                  end else begin
                     starve_cnt <= 4'd0;
                  end
               end else if (i_pend) begin
                  state      <= IBUSY;
                  mem_addr   <= imem_addr;
                  mem_rmask  <= imem_rmask;
                  mem_wmask  <= 4'd0;
                  mem_wdata  <= 32'd0;
                  starve_cnt <= 4'd0;
               end
            end
            IBUSY: begin
               if (mem_resp) begin
                  imem_rdata <= mem_rdata;
                  mem_rmask  <= 4'd0;
                  mem_wmask  <= 4'd0;
                  imem_resp  <= 1'b1;
                  state      <= IRESP;
               end
            end
            DBUSY: begin
               if (mem_resp) begin
                  dmem_rdata <= mem_rdata;
                  mem_rmask  <= 4'd0;
                  mem_wmask  <= 4'd0;
                  dmem_resp  <= 1'b1;
                  state      <= DRESP;
               end
            end
            IRESP:   state <= IDLE;
            DRESP:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - randomized bench with transaction-level reference model
module tb_unified_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] imem_addr = '0;
   logic [3:0]  imem_rmask = '0;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [31:0] dmem_addr = '0;
   logic [3:0]  dmem_rmask = '0;
   logic [3:0]  dmem_wmask = '0;
   logic [31:0] dmem_wdata = '0;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic [31:0] mem_addr;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_resp = 1'b0;
   logic        arb_err;

   unified_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
      .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
      .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .arb_err(arb_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   // reference model: one transaction record plus the run of consecutive data wins
   logic        m_active = 0, m_done = 0, m_imem = 0, m_err = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_irdata = '0, m_drdata = '0;
   logic [3:0]  m_rmask = '0, m_wmask = '0;
   int          dwins = 0;

   // stimulus controls
   logic auto_i = 0, auto_d = 0, cont_i = 0, cont_d = 0, mem_auto = 0, stale_en = 0, allow_ill = 0;
   logic fix_data = 0;
   logic [31:0] data_val = '0;
   int fixed_delay = 0;
   int mdelay = 0;
   logic prev_busy = 0;
   logic [31:0] g_addr[$];
   int g_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      logic ip, dp;
      if (!rst) begin
         m_active = 0; m_done = 0; m_irdata = '0; m_drdata = '0; m_err = 0; dwins = 0;
      end else begin
         ip = (imem_rmask != 0);
         dp = ((dmem_rmask | dmem_wmask) != 0);
         if (!m_active) begin
            if (dp && !(ip && dwins == LIMIT)) begin
               m_active = 1; m_imem = 0; m_addr = dmem_addr; m_wdata = dmem_wdata;
               m_wmask = dmem_wmask;
               m_rmask = (dmem_wmask != 0) ? 4'h0 : dmem_rmask;
               if (dmem_rmask != 0 && dmem_wmask != 0) m_err = 1;
               dwins = ip ? ((dwins < LIMIT) ? dwins + 1 : LIMIT) : 0;
            end else if (ip) begin
               m_active = 1; m_imem = 1; m_addr = imem_addr; m_rmask = imem_rmask;
               m_wmask = 4'h0; m_wdata = '0; dwins = 0;
            end
         end else if (!m_done) begin
            if (mem_resp) begin
               m_done = 1;
               if (m_imem) m_irdata = mem_rdata;
               else m_drdata = mem_rdata;
            end
         end else begin
            m_active = 0; m_done = 0;
         end
      end
   endtask

   task automatic issue_i();
      logic [31:0] a;
      a = $urandom;
      imem_addr = {4'h6, a[27:2], 2'b00};
      imem_rmask = 4'($urandom_range(1, 15));
   endtask

   task automatic issue_d();
      logic [31:0] a;
      int r;
      a = $urandom;
      r = $urandom_range(0, 19);
      dmem_addr = {4'h8, a[27:0]};
      dmem_wdata = $urandom;
      if (r < 8) begin
         dmem_rmask = 4'($urandom_range(1, 15)); dmem_wmask = 4'h0;
      end else if (r < 19 || !allow_ill) begin
         dmem_rmask = 4'h0; dmem_wmask = 4'($urandom_range(1, 15));
      end else begin
         dmem_rmask = 4'($urandom_range(1, 15)); dmem_wmask = 4'($urandom_range(1, 15));
      end
   endtask

   task automatic drive_auto();
      if (auto_i) begin
         if (imem_resp) begin
            if (cont_i) issue_i(); else imem_rmask = 4'h0;
         end else if (imem_rmask == 0 && $urandom_range(0, 2) == 0) issue_i();
      end
      if (auto_d) begin
         if (dmem_resp) begin
            if (cont_d) issue_d(); else begin dmem_rmask = 4'h0; dmem_wmask = 4'h0; end
         end else if ((dmem_rmask | dmem_wmask) == 0 && $urandom_range(0, 2) == 0) issue_d();
      end
      if (mem_auto) begin
         mem_rdata = fix_data ? data_val : $urandom;
         if (mem_resp) mem_resp = 1'b0;
         else if ((mem_rmask | mem_wmask) != 0) begin
            if (mdelay == 0) begin
               mem_resp = 1'b1;
               mdelay = (fixed_delay > 0) ? fixed_delay - 1 : $urandom_range(0, 3);
            end else mdelay--;
         end else if (stale_en && $urandom_range(0, 7) == 0) mem_resp = 1'b1;
      end
   endtask

   task automatic compare_all();
      logic busy;
      busy = m_active && !m_done;
      chk("mem_rmask", 32'(mem_rmask), busy ? 32'(m_rmask) : 32'h0);
      chk("mem_wmask", 32'(mem_wmask), busy ? 32'(m_wmask) : 32'h0);
      if (busy) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("imem_resp", 32'(imem_resp), 32'(m_active && m_done && m_imem));
      chk("dmem_resp", 32'(dmem_resp), 32'(m_active && m_done && !m_imem));
      chk("imem_rdata", imem_rdata, m_irdata);
      chk("dmem_rdata", dmem_rdata, m_drdata);
      chk("arb_err", 32'(arb_err), 32'(m_err));
      if ((mem_rmask | mem_wmask) != 0 && !prev_busy) begin
         g_addr.push_back(mem_addr);
         g_cyc.push_back(cyc);
      end
      prev_busy = ((mem_rmask | mem_wmask) != 0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      drive_auto();
      @(negedge clk);
      compare_all();
      cyc++;
   endtask

   initial begin
      int held, got, mr_cyc, dr_cyc;
      logic seen;

      // reset state
      cycle(); cycle();
      chk("rst_mem_rmask", 32'(mem_rmask), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_imem_resp", 32'(imem_resp), 32'h0);
      chk("rst_arb_err", 32'(arb_err), 32'h0);
      rst = 1'b1;
      cycle();

      // reset during an outstanding fetch, then a stale memory completion
      imem_addr = 32'h1000_0000; imem_rmask = 4'hF;
      cycle();
      chk("abort_grant_addr", mem_addr, 32'h1000_0000);
      cycle();
      rst = 1'b0; imem_rmask = 4'h0;
      cycle(); cycle();
      rst = 1'b1;
      cycle();
      mem_resp = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      cycle();
      chk("abort_no_resp", 32'(imem_resp), 32'h0);
      chk("abort_mem_rmask", 32'(mem_rmask), 32'h0);
      chk("abort_rdata", imem_rdata, 32'h0);
      mem_resp = 1'b0;
      cycle();
      chk("abort_no_resp_late", 32'(imem_resp), 32'h0);

      // single fetch with a 3-cycle memory
      mem_auto = 1; fixed_delay = 3; mdelay = 2; fix_data = 1; data_val = 32'h0000_0013;
      imem_addr = 32'h6000_0000; imem_rmask = 4'hF;
      held = 0; got = 0;
      for (int k = 0; k < 12; k++) begin
         cycle();
         if (mem_rmask == 4'hF) held++;
         if (imem_resp) begin
            got++;
            chk("fetch_rdata", imem_rdata, 32'h0000_0013);
            imem_rmask = 4'h0;
         end
      end
      chk("fetch_hold_cycles", 32'(held), 32'd3);
      chk("fetch_resp_count", 32'(got), 32'd1);
      chk("model_fetch_rdata", m_irdata, 32'h0000_0013);

      // simultaneous requests: data first, fetch three cycles later
      fix_data = 0; fixed_delay = 1; mdelay = 0;
      g_addr.delete(); g_cyc.delete();
      imem_addr = 32'h6000_0004; imem_rmask = 4'hF;
      dmem_addr = 32'h8000_0010; dmem_rmask = 4'h3; dmem_wmask = 4'h0;
      for (int k = 0; k < 14; k++) begin
         cycle();
         if (imem_resp) imem_rmask = 4'h0;
         if (dmem_resp) dmem_rmask = 4'h0;
      end
      chk("simul_grant_count", 32'(g_addr.size()), 32'd2);
      if (g_addr.size() >= 2) begin
         chk("simul_first", g_addr[0], 32'h8000_0010);
         chk("simul_second", g_addr[1], 32'h6000_0004);
         chk("simul_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd3);
      end

      // store
      fixed_delay = 2; mdelay = 1;
      dmem_addr = 32'h8000_0020; dmem_wmask = 4'hC; dmem_wdata = 32'hDEAD_BEEF; dmem_rmask = 4'h0;
      seen = 0; got = 0; mr_cyc = -100; dr_cyc = 0;
      for (int k = 0; k < 12; k++) begin
         cycle();
         if ((mem_rmask | mem_wmask) != 0 && !seen) begin
            seen = 1;
            chk("store_wmask", 32'(mem_wmask), 32'hC);
            chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("store_rmask", 32'(mem_rmask), 32'h0);
         end
         if (mem_resp) mr_cyc = cyc;
         if (dmem_resp) begin
            got++; dr_cyc = cyc; dmem_wmask = 4'h0;
         end
      end
      chk("store_resp_count", 32'(got), 32'd1);
      chk("store_resp_latency", 32'(dr_cyc - mr_cyc), 32'd1);

      // illegal request performed as a store, sticky error
      fixed_delay = 1; mdelay = 0;
      dmem_addr = 32'h8000_0030; dmem_rmask = 4'hF; dmem_wmask = 4'hF; dmem_wdata = 32'h1234_5678;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if ((mem_rmask | mem_wmask) != 0 && !seen) begin
            seen = 1;
            chk("ill_wmask", 32'(mem_wmask), 32'hF);
            chk("ill_rmask", 32'(mem_rmask), 32'h0);
         end
         if (dmem_resp) begin dmem_rmask = 4'h0; dmem_wmask = 4'h0; end
      end
      chk("ill_err_set", 32'(arb_err), 32'h1);
      chk("model_ill_err", 32'(m_err), 32'h1);
      cycle(); cycle(); cycle();
      chk("ill_err_sticky", 32'(arb_err), 32'h1);
      rst = 1'b0;
      cycle();
      chk("ill_err_cleared", 32'(arb_err), 32'h0);
      rst = 1'b1;
      cycle();

      // starvation: both requesters continuously pending
      fixed_delay = 0; mdelay = 0; allow_ill = 0;
      g_addr.delete(); g_cyc.delete();
      auto_i = 1; auto_d = 1; cont_i = 1; cont_d = 1;
      issue_i(); issue_d();
      for (int k = 0; k < 200 && g_addr.size() < 10; k++) cycle();
      chk("starve_grant_count", 32'(g_addr.size() >= 10), 32'h1);
      for (int k = 0; k < 10 && k < g_addr.size(); k++)
         chk("starve_order", 32'(g_addr[k][31:28]), (k % 5 == 4) ? 32'h6 : 32'h8);

      // randomized traffic with stale completions and occasional illegal requests
      cont_i = 0; cont_d = 0; stale_en = 1; allow_ill = 1;
      for (int k = 0; k < 2500; k++) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
